// File: rtl/mips_if_ctrl.sv
// Fetch-stage sequencer: owns the PC and the I-cache read port, picks the next PC,
// rides out I-cache misses (including redirects that land mid-miss) and drives IF/ID.
module mips_if_ctrl #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
    parameter int unsigned             CNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   bjp_req_i,
    input  logic [ADDR_WIDTH-1:0]  prdt_pc_i,
    input  logic [ADDR_WIDTH-1:0]  pc_incr_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    input  logic                   I_ready,
    output logic                   I_read,
    output logic [ADDR_WIDTH-3:0]  I_addr,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   if2id_we,
    output logic                   if2id_flush,
    output logic                   redirect_pending,
    output logic [CNT_WIDTH-1:0]   fetch_cnt,
    output logic [CNT_WIDTH-1:0]   miss_cyc_cnt
);

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        FETCH     = 2'd1,
        MISS      = 2'd2,
        MISS_KILL = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   pc_n;
    logic [ADDR_WIDTH-1:0]   kill_pc, kill_pc_n;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic                    hit;
    logic                    in_miss;

    // State, PC, kill address and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc_o         <= RESET_PC;
            kill_pc      <= '0;
            fetch_cnt    <= '0;
            miss_cyc_cnt <= '0;
        end else begin
            state   <= state_n;
            pc_o    <= pc_n;
            kill_pc <= kill_pc_n;
            if (hit && (fetch_cnt != '1))
                fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
            if (in_miss && (miss_cyc_cnt != '1))
                miss_cyc_cnt <= miss_cyc_cnt + CNT_WIDTH'(1);
        end
    end

    // Next-state, next-PC and fetch-port controls.
    always_comb begin
        state_n          = state;
        pc_n             = pc_o;
        kill_pc_n        = kill_pc;
        I_read           = 1'b0;
        if2id_we         = 1'b0;
        if2id_flush      = 1'b0;
        redirect_pending = 1'b0;
        hit              = 1'b0;
        in_miss          = (state == MISS) || (state == MISS_KILL);

        case (state)
            BOOT: begin
                state_n = FETCH;
            end
            FETCH, MISS: begin
                I_read = 1'b1;
                if (redirect_i) begin
                    pc_n        = redirect_pc_i;
                    if2id_flush = 1'b1;
                    if (!I_ready) begin
                        kill_pc_n = pc_o;
                        state_n   = MISS_KILL;
                    end else begin
                        state_n = FETCH;
                    end
                end else if (!I_ready) begin
                    state_n = MISS;
                end else if (stall_i) begin
                    state_n = FETCH;
                end else begin
                    hit      = 1'b1;
                    if2id_we = 1'b1;
                    pc_n     = bjp_req_i ? prdt_pc_i : pc_incr_i;
                    state_n  = FETCH;
                end
            end
            MISS_KILL: begin
                // Outstanding read on kill_pc completes and is dropped; pc_o keeps the target.
                I_read           = 1'b1;
                redirect_pending = 1'b1;
                if (redirect_i) begin
                    pc_n        = redirect_pc_i;
                    if2id_flush = 1'b1;
                end
                if (I_ready)
                    state_n = FETCH;
            end
            default: begin
                state_n = BOOT;
            end
        endcase

        if (rst) begin
            I_read           = 1'b0;
            if2id_we         = 1'b0;
            if2id_flush      = 1'b0;
            redirect_pending = 1'b0;
            hit              = 1'b0;
            in_miss          = 1'b0;
        end
    end

    assign fetch_addr = (state == MISS_KILL) ? kill_pc : pc_o;
    assign I_addr     = fetch_addr[ADDR_WIDTH-1:2];

endmodule

// File: tb/tb_mips_if_ctrl.sv
// Directed bench for mips_if_ctrl: hits, predicted-taken, misses, mid-miss redirects,
// stall/redirect priority, mid-miss reset and counter saturation (4-bit counters).
module tb_mips_if_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    logic           clk;
    logic           rst;
    logic           stall_i;
    logic           bjp_req_i;
    logic [AW-1:0]  prdt_pc_i;
    logic [AW-1:0]  pc_incr_i;
    logic           redirect_i;
    logic [AW-1:0]  redirect_pc_i;
    logic           I_ready;
    logic           I_read;
    logic [AW-3:0]  I_addr;
    logic [AW-1:0]  pc_o;
    logic           if2id_we;
    logic           if2id_flush;
    logic           redirect_pending;
    logic [CW-1:0]  fetch_cnt;
    logic [CW-1:0]  miss_cyc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mips_if_ctrl #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (32'h0000_0000),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .bjp_req_i        (bjp_req_i),
        .prdt_pc_i        (prdt_pc_i),
        .pc_incr_i        (pc_incr_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .I_ready          (I_ready),
        .I_read           (I_read),
        .I_addr           (I_addr),
        .pc_o             (pc_o),
        .if2id_we         (if2id_we),
        .if2id_flush      (if2id_flush),
        .redirect_pending (redirect_pending),
        .fetch_cnt        (fetch_cnt),
        .miss_cyc_cnt     (miss_cyc_cnt)
    );

    // IF datapath adder
    assign pc_incr_i = pc_o + 32'd4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; bjp_req_i = 1'b0; prdt_pc_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; I_ready = 1'b0;
        step();
        check("rst_pc", pc_o, 32'h0);
        check("rst_fcnt", 32'(fetch_cnt), 32'd0);
        check("rst_mcnt", 32'(miss_cyc_cnt), 32'd0);
        check("rst_read", 32'(I_read), 32'd0);

        // BOOT cycle: no read, redirect ignored
        rst = 1'b0; I_ready = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        #1;
        check("boot_read", 32'(I_read), 32'd0);
        check("boot_flush", 32'(if2id_flush), 32'd0);
        check("boot_we", 32'(if2id_we), 32'd0);
        step();
        redirect_i = 1'b0;
        #1;
        check("hit0_pc", pc_o, 32'h0);
        check("hit0_read", 32'(I_read), 32'd1);
        check("hit0_we", 32'(if2id_we), 32'd1);
        check("hit0_addr", 32'(I_addr), 32'h0);
        step();
        check("hit1_pc", pc_o, 32'h4);
        check("hit1_we", 32'(if2id_we), 32'd1);
        step();
        check("hit2_pc", pc_o, 32'h8);
        bjp_req_i = 1'b1; prdt_pc_i = 32'h40;
        #1;
        check("bjp_we", 32'(if2id_we), 32'd1);
        check("bjp_flush", 32'(if2id_flush), 32'd0);
        step();
        bjp_req_i = 1'b0;
        check("bjp_pc", pc_o, 32'h40);
        check("fcnt3", 32'(fetch_cnt), 32'd3);

        // Redirect from FETCH with a hit: 1-cycle turnaround to 0x10
        redirect_i = 1'b1; redirect_pc_i = 32'h10;
        #1;
        check("rd_flush", 32'(if2id_flush), 32'd1);
        check("rd_we", 32'(if2id_we), 32'd0);
        step();
        redirect_i = 1'b0; I_ready = 1'b0;
        check("rd_pc", pc_o, 32'h10);

        // Plain miss, I_ready low for 3 cycles
        for (int i = 0; i < 3; i++) begin
            #1;
            check("miss_we", 32'(if2id_we), 32'd0);
            check("miss_addr", 32'(I_addr), 32'h4);
            check("miss_pend", 32'(redirect_pending), 32'd0);
            step();
        end
        check("miss_pc_hold", pc_o, 32'h10);
        I_ready = 1'b1;
        #1;
        check("miss_done_we", 32'(if2id_we), 32'd1);
        step();
        check("miss_done_pc", pc_o, 32'h14);
        check("miss_cnt3", 32'(miss_cyc_cnt), 32'd3);
        check("fcnt4", 32'(fetch_cnt), 32'd4);

        // Back to 0x10, then miss and redirect to 0x80 while in MISS
        redirect_i = 1'b1; redirect_pc_i = 32'h10;
        step();
        redirect_i = 1'b0; I_ready = 1'b0;
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        #1;
        check("mk_flush", 32'(if2id_flush), 32'd1);
        check("mk_we", 32'(if2id_we), 32'd0);
        check("mk_addr0", 32'(I_addr), 32'h4);
        step();
        redirect_i = 1'b0;
        #1;
        check("mk_pend", 32'(redirect_pending), 32'd1);
        check("mk_addr1", 32'(I_addr), 32'h4);
        check("mk_pc", pc_o, 32'h80);
        check("mk_flush_off", 32'(if2id_flush), 32'd0);
        step();
        I_ready = 1'b1;
        #1;
        check("mk_kill_we", 32'(if2id_we), 32'd0);
        check("mk_kill_addr", 32'(I_addr), 32'h4);
        check("mk_kill_read", 32'(I_read), 32'd1);
        step();
        check("mk_resume_addr", 32'(I_addr), 32'h20);
        check("mk_resume_pend", 32'(redirect_pending), 32'd0);
        check("mk_mcnt", 32'(miss_cyc_cnt), 32'd6);

        // Redirect + stall + predict-taken all at once: redirect wins
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        bjp_req_i = 1'b1; prdt_pc_i = 32'h40;
        #1;
        check("conf_flush", 32'(if2id_flush), 32'd1);
        check("conf_we", 32'(if2id_we), 32'd0);
        step();
        redirect_i = 1'b0; bjp_req_i = 1'b0;
        check("conf_pc", pc_o, 32'h100);
        check("conf_pend", 32'(redirect_pending), 32'd0);
        check("conf_fcnt", 32'(fetch_cnt), 32'd4);

        // Stall with a hit: hold PC, no load
        #1;
        check("stall_we", 32'(if2id_we), 32'd0);
        check("stall_flush", 32'(if2id_flush), 32'd0);
        step();
        check("stall_pc", pc_o, 32'h100);

        // Stall + miss -> MISS, then redirect into MISS_KILL, then reset
        I_ready = 1'b0;
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        check("pre_rst_pend", 32'(redirect_pending), 32'd1);
        rst = 1'b1; stall_i = 1'b0;
        #1;
        check("rst_force_read", 32'(I_read), 32'd0);
        check("rst_force_pend", 32'(redirect_pending), 32'd0);
        step();
        check("midrst_pc", pc_o, 32'h0);
        check("midrst_fcnt", 32'(fetch_cnt), 32'd0);
        check("midrst_mcnt", 32'(miss_cyc_cnt), 32'd0);
        check("midrst_boot", 32'(I_read), 32'd0);

        // 20-cycle miss saturates the 4-bit miss counter
        rst = 1'b0;
        step();
        for (int i = 0; i < 20; i++) step();
        check("sat_mcnt", 32'(miss_cyc_cnt), 32'd15);
        step();
        step();
        check("sat_hold", 32'(miss_cyc_cnt), 32'd15);
        check("sat_pc", pc_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
